// File: rtl/serial_ripple_subtractor.sv
// Bit-serial borrow-ripple subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused across WIDTH cycles behind a start/busy/done handshake.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] areg, breg, shreg;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             load, last, dbit, brnx;

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign dbit = areg[0] ^ breg[0] ^ br;
  assign brnx = (~areg[0] & breg[0]) | (~(areg[0] ^ breg[0]) & br);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Start is honoured only in IDLE or DONE; DONE lasts one cycle either way.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_nx = RUN;
          load     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The output register is loaded only at the final RUN edge, so partial sums never show.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      areg  <= '0;
      breg  <= '0;
      shreg <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else if (load) begin
      areg  <= a;
      breg  <= b;
      br    <= bin;
      shreg <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      areg  <= areg >> 1;
      breg  <= breg >> 1;
      shreg <= {dbit, shreg[WIDTH-1:1]};
      br    <= brnx;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        diff <= {dbit, shreg[WIDTH-1:1]};
        bout <= brnx;
      end
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard bench for serial_ripple_subtractor: stimulus pushes a-b-bin expectations,
// an independent monitor pops them whenever done pulses.
`timescale 1ns/1ps
module tb_serial_ripple_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, start, bin;
  logic [W-1:0] a, b, diff;
  logic         bout, busy, done;

  logic [W:0] expq[$];
  int checks = 0, errors = 0;
  int cycle = 0, busyRun = 0, lastDone = 0, b2bDones = 0;
  bit b2b = 0;

  serial_ripple_subtractor #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .diff(diff), .bout(bout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  function automatic logic [W:0] refSub(input int x, input int y, input int c);
    int r;
    logic [W:0] res;
    r = x - y - c;
    res[W-1:0] = W'(r);
    res[W]     = (r < 0);
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks handshake timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      busyRun = 0;
    end else begin
      if (busy) busyRun++;
      if (done) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got diff=%0h bout=%0b expected no done", diff, bout);
        end else begin
          checkOutput("result", 32'({bout, diff}), 32'(expq.pop_front()));
        end
        checkOutput("busy_in_done", 32'(busy), 32'd0);
        checkOutput("busy_cycles", 32'(busyRun), 32'(W));
        if (b2b && b2bDones > 0) checkOutput("done_spacing", 32'(cycle - lastDone), 32'(W + 1));
        if (b2b) b2bDones++;
        lastDone = cycle;
        busyRun  = 0;
      end else if (!busy) begin
        busyRun = 0;
      end
    end
  end

  task automatic waitDrain();
    int n = 0;
    while (expq.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (expq.size() != 0) begin
      checkOutput("timeout", 32'(expq.size()), 32'd0);
      expq.delete();
    end
  endtask

  // Called just after a posedge with the DUT idle; returns aligned the same way.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] e;
    e = refSub(int'(x), int'(y), int'(c));
    a = x; b = y; bin = c; start = 1'b1;
    expq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    waitDrain();
    @(negedge clk);
    checkOutput("hold", 32'({bout, diff}), 32'(e));
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_diff", 32'(diff), 32'd0);
    checkOutput("reset_bout", 32'(bout), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(4'd5, 4'd3, 1'b0);
    applyStimulus(4'd0, 4'd1, 1'b0);
    applyStimulus(4'd2, 4'd3, 1'b1);
    applyStimulus(4'd4, 4'd2, 1'b1);
    applyStimulus(4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(W'($urandom), W'($urandom), 1'($urandom));

    // Start held high with fresh operands every cycle; only every W+1th set is taken.
    b2b = 1; b2bDones = 0;
    start = 1'b1;
    for (int i = 0; i < 4 * (W + 1); i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      if (i % (W + 1) == 0) expq.push_back(refSub(int'(a), int'(b), int'(bin)));
      @(posedge clk); #1;
    end
    start = 1'b0;
    waitDrain();
    checkOutput("b2b_count", 32'(b2bDones), 32'd4);
    b2b = 0;
    @(posedge clk); #1;

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          applyStimulus(W'(x), W'(y), 1'(c));

    // Abort in the second RUN cycle: no done may follow and outputs clear.
    a = 4'd7; b = 4'd1; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_diff", 32'(diff), 32'd0);
    checkOutput("abort_bout", 32'(bout), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    applyStimulus(4'd9, 4'd4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
